bitstream_packer: RTL
=====================

BITSTREAM_PACKER -- requirements
Module: bitstream_packer

Interface
REQ-001 SHALL have parameter BUF_BITS, default 64, bit-accumulator capacity; legal values 40..64.
REQ-002 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_bits  input  32  variable-length field, right-justified, MSB of the field sent first.
REQ-005 SHALL have port in_length  input  6  field length in bits, 0..32.
REQ-006 SHALL have port in_valid  input  1  in_bits/in_length valid.
REQ-007 SHALL have port in_ready  output  1  packer can accept a field this cycle.
REQ-008 SHALL have port flush  input  1  single-cycle request to end the scan (pad and drain).
REQ-009 SHALL have port out_byte  output  8  packed JPEG entropy-coded byte.
REQ-010 SHALL have port out_valid  output  1  out_byte valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts out_byte.
REQ-012 SHALL have port flush_done  output  1  one-cycle pulse after the last flushed byte is accepted.

Function
REQ-013 SHALL accept a field when in_valid && in_ready; bits above in_length are ignored; in_length 0 is a no-op.
REQ-014 SHALL drive in_ready = (count <= BUF_BITS-32) && state==RUN, count being the number of unsent bits held.
REQ-015 SHALL append accepted bits MSB-first behind held bits; count saturation is impossible by REQ-014.
REQ-016 SHALL load the output register with the oldest 8 held bits whenever count >= 8 and the output register is empty or being accepted this cycle.
REQ-017 SHALL allow field accept and byte load in the same cycle: count_next = count + in_length - 8.
REQ-018 SHALL hold out_byte and out_valid stable while out_valid && !out_ready.
REQ-019 SHALL, after any 0xFF byte is accepted, emit a stuffed 0x00 as the very next byte, before any further data byte (state STUFF).
REQ-020 SHALL implement states RUN, STUFF, FLUSH, DONE; RUN->STUFF on accept of 0xFF; STUFF->RUN (or FLUSH if flush pending) on accept of 0x00.
REQ-021 SHALL register flush in any state; RUN->FLUSH when flush is pending; in_ready is 0 in FLUSH and DONE.
REQ-022 SHALL in FLUSH drain whole bytes, then, if 1..7 bits remain, pad with 1s to a full byte and emit it (stuffed per REQ-019 if it equals 0xFF).
REQ-023 SHALL enter DONE when count==0, no stuff pending and output register empty; DONE pulses flush_done for one cycle then returns to RUN.
REQ-024 SHALL never emit a byte with out_valid while flush is being processed other than data, stuff and pad bytes; flush with empty buffer gives flush_done with no bytes.
REQ-025 SHALL have one-cycle minimum latency: a byte-completing field accepted in cycle N appears on out_byte in cycle N+1.

Reset
REQ-026 SHALL on reset_n low asynchronously set state=RUN, count=0, accumulator=0, out_byte=0x00, out_valid=0, flush_done=0, flush pending=0.
REQ-027 SHALL discard all held bits and any pending stuff/flush on reset mid-operation; in_ready is 0 while reset_n is low and rises the first cycle after release.

Structure
REQ-028 SHALL place state encoding (RUN, STUFF, FLUSH, DONE), the 0xFF marker and 0x00 stuff constants in a shared jpeg package.
REQ-029 SHALL be a single module; no sub-module.

Verification
REQ-030 SHALL test: field 0xA5 length 8 -> one byte 0xA5 next cycle, no stuffing.
REQ-031 SHALL test: field 0xFF length 8 -> bytes 0xFF then 0x00; field 0x7F8 length 12 then flush -> 0x7F, 0x8F.
REQ-032 SHALL test: field 3'b101 length 3, flush -> single byte 0xBF then flush_done; flush on empty -> flush_done, no bytes.
REQ-033 SHALL test: out_ready low 20 cycles while offering 32-bit fields -> in_ready drops at count > BUF_BITS-32; byte order intact after release.
REQ-034 SHALL test: out_ready toggling randomly, 1000 random fields lengths 0..32 -> unstuffed output bitstream equals concatenated input plus 1-padding.
REQ-035 SHALL test: reset_n pulsed low with 13 bits held and out_valid=1 -> all outputs at reset values immediately, no stale byte afterwards.

Source files
------------

// File: rtl/bitstream_packer_pkg.sv
// Shared JPEG entropy-coder constants: packer FSM encoding, the 0xFF marker
// and the 0x00 stuff byte, plus a field-masking helper.
package bitstream_packer_pkg;

  localparam int CNT_W = 7;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_STUFF = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [7:0] JPEG_MARKER = 8'hFF;
  localparam logic [7:0] JPEG_STUFF  = 8'h00;

  // Ones in the low len bits; len is already clamped to 0..32.
  function automatic logic [31:0] field_mask(input logic [5:0] len);
    return 32'hFFFF_FFFF >> (6'd32 - len);
  endfunction

endpackage

// File: rtl/bitstream_packer.sv
// Packs right-justified variable-length fields MSB-first into bytes, inserts a
// 0x00 after every 0xFF, and on flush pads the tail with 1s and drains.
module bitstream_packer
  import bitstream_packer_pkg::*;
#(
  parameter int BUF_BITS = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] in_bits,
  input  logic [5:0]  in_length,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        flush,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        flush_done
);

  logic [1:0]          state, state_nx;
  logic [CNT_W-1:0]    count, count_nx, cnt_comb;
  logic [BUF_BITS-1:0] acc, acc_nx, acc_comb;
  logic [7:0]          byte_nx, data_byte, pad_byte;
  logic                vld_nx;
  logic                flush_pend, pend_nx;
  logic                run_en;
  logic [5:0]          len;
  logic                accept, slot_free;

  assign len       = in_length[5] ? 6'd32 : in_length;
  assign in_ready  = run_en && (count <= CNT_W'(BUF_BITS - 32)) && (state == ST_RUN);
  assign accept    = in_valid && in_ready;
  assign slot_free = !out_valid || out_ready;

  // Held bits are right-justified; the oldest unsent bit sits at cnt_comb-1.
  // The incoming field is merged before byte extraction so a completing field
  // reaches out_byte on the very next edge.
  assign acc_comb  = accept ? ((acc << len) | BUF_BITS'(in_bits & field_mask(len))) : acc;
  assign cnt_comb  = accept ? (count + CNT_W'(len)) : count;
  assign data_byte = 8'(acc_comb >> (cnt_comb - CNT_W'(8)));
  assign pad_byte  = 8'(acc_comb << (4'd8 - {1'b0, cnt_comb[2:0]})) | (8'hFF >> cnt_comb[2:0]);

  always_comb begin
    state_nx = state;
    count_nx = cnt_comb;
    acc_nx   = acc_comb;
    byte_nx  = out_byte;
    vld_nx   = out_valid;
    pend_nx  = flush_pend || flush;

    case (state)
      ST_RUN:   if (flush_pend) state_nx = ST_FLUSH;
      ST_STUFF: if (out_ready) state_nx = flush_pend ? ST_FLUSH : ST_RUN;
      ST_FLUSH: begin
        if (count == '0 && !out_valid) begin
          state_nx = ST_DONE;
          pend_nx  = flush;
        end
      end
      default:  state_nx = ST_RUN;
    endcase

    // A departing 0xFF always claims the output slot for its stuff byte.
    if (slot_free) begin
      if (out_valid && out_byte == JPEG_MARKER) begin
        byte_nx  = JPEG_STUFF;
        vld_nx   = 1'b1;
        state_nx = ST_STUFF;
      end else if (cnt_comb >= CNT_W'(8)) begin
        byte_nx  = data_byte;
        vld_nx   = 1'b1;
        count_nx = cnt_comb - CNT_W'(8);
      end else if (state == ST_FLUSH && cnt_comb != '0) begin
        byte_nx  = pad_byte;
        vld_nx   = 1'b1;
        count_nx = '0;
      end else begin
        vld_nx   = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_RUN;
      count      <= '0;
      acc        <= '0;
      out_byte   <= 8'h00;
      out_valid  <= 1'b0;
      flush_done <= 1'b0;
      flush_pend <= 1'b0;
      run_en     <= 1'b0;
    end else begin
      state      <= state_nx;
      count      <= count_nx;
      acc        <= acc_nx;
      out_byte   <= byte_nx;
      out_valid  <= vld_nx;
      flush_done <= (state_nx == ST_DONE);
      flush_pend <= pend_nx;
      run_en     <= 1'b1;
    end
  end

endmodule
